radix4_multiple_select: RTL

//  Radix-4 digit sequencer downstream of the 1x/2x/3x multiple precompute stage in the Montgomery datapath.

---
 rtl/radix4_multiple_select_if.sv | 36 +++
 rtl/radix4_multiple_select.sv | 112 +++++++++++
 2 files changed

// File: rtl/radix4_multiple_select_if.sv
// ---------------------------------------------------------------------------
// Module  : radix4_multiple_select_if
// Brief   : Bus between the precompute stage, the digit sequencer and the accumulator.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface radix4_multiple_select_if #(
    parameter int N = 1024
);
    logic           start;
    logic [N-1:0]   b;
    logic           mult_done;
    logic [N-1:0]   operand;
    logic [N:0]     operand_2;
    logic [N+3:0]   operand_3;
    logic           digit_ready;
    logic           digit_valid;
    logic [1:0]     digit;
    logic [N+3:0]   multiple_out;
    logic           last;
    logic           busy;
    logic           done;

    modport master (
        output start, b, mult_done, operand, operand_2, operand_3, digit_ready,
        input  digit_valid, digit, multiple_out, last, busy, done
    );

    modport slave (
        input  start, b, mult_done, operand, operand_2, operand_3, digit_ready,
        output digit_valid, digit, multiple_out, last, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/radix4_multiple_select.sv
// ---------------------------------------------------------------------------
// Module  : radix4_multiple_select
// Brief   : Scans B two bits at a time (LSB first) and streams 0/A/2A/3A per digit.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module radix4_multiple_select #(
    parameter int N     = 1024,
    parameter int CNT_W = 9
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    radix4_multiple_select_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(N/2 - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [N-1:0]       r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       r_a;
    logic [N:0]         r_a2;
    logic [N+3:0]       r_a3;
    logic               r_loaded;
    logic               w_handshake;
    logic               w_final;

    assign w_handshake = (r_state == RUN) && bus.digit_ready;
    assign w_final     = w_handshake && (r_cnt == c_last_cnt);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = LOAD;
            LOAD:    if (r_loaded)  w_state_next = RUN;
            RUN:     if (w_final)   w_state_next = FINISH;
            FINISH:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The counter stops at the final digit rather than wrapping; it is reloaded on start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_b   <= '0;
            r_cnt <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_b   <= bus.b;
            r_cnt <= '0;
        end else if (w_handshake) begin
            r_b <= r_b >> 2;
            if (!w_final) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Multiples are frozen for the whole scan so a new precompute cannot corrupt it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_a2     <= '0;
            r_a3     <= '0;
            r_loaded <= 1'b0;
        end else if (bus.mult_done && r_state != RUN) begin
            r_a      <= bus.operand;
            r_a2     <= bus.operand_2;
            r_a3     <= bus.operand_3;
            r_loaded <= 1'b1;
        end else if (w_final) begin
            r_loaded <= 1'b0;
        end
    end

    always_comb begin
        bus.digit_valid  = 1'b0;
        bus.digit        = 2'b00;
        bus.multiple_out = '0;
        bus.last         = 1'b0;
        bus.busy         = (r_state != IDLE);
        bus.done         = (r_state == FINISH);
        if (r_state == RUN) begin
            bus.digit_valid = 1'b1;
            bus.digit       = r_b[1:0];
            bus.last        = (r_cnt == c_last_cnt);
            case (r_b[1:0])
                2'b01:   bus.multiple_out = {4'b0000, r_a};
                2'b10:   bus.multiple_out = {3'b000, r_a2};
                2'b11:   bus.multiple_out = r_a3;
                default: bus.multiple_out = '0;
            endcase
        end
    end
endmodule

`default_nettype wire
